// File: rtl/bus_copy_master_pkg.sv
// Shared definitions for the bus copy master: bus widths, FSM states, bus direction codes.
package bus_copy_master_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 32;
   localparam int LW_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_RD   = 3'd2,
      ST_CAP  = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   localparam logic BUS_READ  = 1'b0;
   localparam logic BUS_WRITE = 1'b1;

endpackage

// File: rtl/bus_copy_master_if.sv
// Request/grant bus between the copy master and the single-master BUS block.
interface bus_copy_master_if
   import bus_copy_master_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          M_req;
   logic          M_grant;
   logic          M_wr;
   logic [AW-1:0] M_addr;
   logic [DW-1:0] M_dout;
   logic [DW-1:0] M_din;

   modport master (output M_req, M_wr, M_addr, M_dout, input M_grant, M_din);
   modport slave  (input M_req, M_wr, M_addr, M_dout, output M_grant, M_din);
endinterface

// File: rtl/bus_copy_master_addr_gen.sv
// Holds the latched copy descriptor and word index; produces src+idx, dst+idx and the last-word flag.
module bus_copy_master_addr_gen
   import bus_copy_master_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int LW = LW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic          inc_i,
   input  logic [AW-1:0] src_i,
   input  logic [AW-1:0] dst_i,
   input  logic [LW-1:0] len_i,
   output logic [AW-1:0] src_addr_o,
   output logic [AW-1:0] dst_addr_o,
   output logic          last_o
);

   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] idx_q, idx_d;

   always_comb begin
      src_d = src_q;
      dst_d = dst_q;
      len_d = len_q;
      idx_d = idx_q;
      if (load_i) begin
         src_d = src_i;
         dst_d = dst_i;
         len_d = len_i;
         idx_d = '0;
      end else if (inc_i) begin
         idx_d = idx_q + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
         idx_q <= '0;
      end else begin
         src_q <= src_d;
         dst_q <= dst_d;
         len_q <= len_d;
         idx_q <= idx_d;
      end
   end

   // Addresses wrap naturally at 2^AW.
   assign src_addr_o = src_q + AW'(idx_q);
   assign dst_addr_o = dst_q + AW'(idx_q);
   assign last_o     = (idx_q == (len_q - LW'(1)));

endmodule

// File: rtl/bus_copy_master.sv
// Copy master: reads LEN words from src and writes them to dst over a request/grant bus.
module bus_copy_master
   import bus_copy_master_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int LW = LW_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [AW-1:0]            src_addr,
   input  logic [AW-1:0]            dst_addr,
   input  logic [LW-1:0]            length,
   output logic                     busy,
   output logic                     done,
   bus_copy_master_if.master        bus
);

   state_e        state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   logic          load, inc, last;
   logic [AW-1:0] rd_addr, wr_addr;

   bus_copy_master_addr_gen #(.AW(AW), .LW(LW)) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .inc_i      (inc),
      .src_i      (src_addr),
      .dst_i      (dst_addr),
      .len_i      (length),
      .src_addr_o (rd_addr),
      .dst_addr_o (wr_addr),
      .last_o     (last)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      load    = 1'b0;
      inc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  load    = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_REQ:  if (bus.M_grant) state_d = ST_RD;
         ST_RD:   if (bus.M_grant) state_d = ST_CAP;
         // Losing grant here means M_din may be stale: re-read the same word.
         ST_CAP: begin
            if (bus.M_grant) begin
               data_d  = bus.M_din;
               state_d = ST_WR;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_WR: begin
            if (bus.M_grant) begin
               if (last) begin
                  state_d = ST_DONE;
               end else begin
                  inc     = 1'b1;
                  state_d = ST_RD;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      bus.M_req  = 1'b0;
      bus.M_wr   = BUS_READ;
      bus.M_addr = '0;
      bus.M_dout = '0;
      case (state_q)
         ST_REQ: bus.M_req = 1'b1;
         ST_RD, ST_CAP: begin
            bus.M_req  = 1'b1;
            bus.M_addr = rd_addr;
         end
         ST_WR: begin
            bus.M_req  = 1'b1;
            bus.M_wr   = BUS_WRITE;
            bus.M_addr = wr_addr;
            bus.M_dout = data_q;
         end
         default: ;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench: copy master driving a BUS model with two 32-word register slaves; scoreboard checks writes.
module tb_bus_copy_master;
   import bus_copy_master_pkg::*;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] src_addr, dst_addr;
   logic [LW-1:0] length;
   logic          busy, done;
   logic          gnt_block;

   bus_copy_master_if #(.AW(AW), .DW(DW)) bus ();

   bus_copy_master #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] s0 [32];
   logic [DW-1:0] s1 [32];

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;
   wr_t exp_q[$];

   int checks = 0, errors = 0, nwrites = 0;
   int first_done, done_cnt, req_cnt;
   logic busy_h [0:31];

   function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
      if (a < 8'h20)      return s0[a[4:0]];
      else if (a < 8'h40) return s1[a[4:0]];
      else                return {16'hC0DE, 8'h00, a};
   endfunction

   // BUS + slaves: grant is a registered copy of M_req; reads return one cycle later.
   always @(posedge clk) begin
      if (reset) begin
         bus.M_grant <= 1'b0;
         bus.M_din   <= '0;
         for (int i = 0; i < 32; i++) begin
            s0[i] <= 32'hA0 + 32'(i);
            s1[i] <= 32'h5100_0000 + 32'(i);
         end
      end else begin
         bus.M_grant <= bus.M_req & ~gnt_block;
         bus.M_din   <= (bus.M_req && bus.M_grant && !bus.M_wr) ? rd_model(bus.M_addr) : '0;
         if (bus.M_req && bus.M_grant && bus.M_wr) begin
            if (bus.M_addr < 8'h20)      s0[bus.M_addr[4:0]] <= bus.M_dout;
            else if (bus.M_addr < 8'h40) s1[bus.M_addr[4:0]] <= bus.M_dout;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && bus.M_req && bus.M_grant && bus.M_wr) begin
         wr_t e;
         nwrites++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h, expected no write", bus.M_addr, bus.M_dout);
         end else begin
            e = exp_q.pop_front();
            if (bus.M_addr !== e.a || bus.M_dout !== e.d) begin
               errors++;
               $display("FAIL write: addr=%h data=%h, expected addr=%h data=%h",
                        bus.M_addr, bus.M_dout, e.a, e.d);
            end
         end
      end
   end

   task automatic push_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{a: d + AW'(i), d: rd_model(s + AW'(i))});
   endtask

   // Leaves the caller just after the edge that samples start (early in cycle t1).
   task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
      @(posedge clk); #1;
      start = 1'b1; src_addr = s; dst_addr = d; length = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Observe n cycles from t1; optional grant blocking and a stray start pulse.
   task automatic watch(input int ncyc, input int blk_lo, input int blk_hi, input int st_at);
      first_done = -1; done_cnt = 0; req_cnt = 0;
      for (int n = 1; n <= ncyc; n++) begin
         gnt_block = (n >= blk_lo) && (n <= blk_hi);
         start     = (n == st_at);
         if (n == st_at) begin
            src_addr = 8'h10; dst_addr = 8'h30; length = 8'd2;
         end
         @(negedge clk);
         busy_h[n] = busy;
         if (done) begin
            done_cnt++;
            if (first_done < 0) first_done = n;
         end
         if (bus.M_req) req_cnt++;
         @(posedge clk); #1;
      end
      gnt_block = 1'b0;
      start     = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; gnt_block = 1'b0;
      src_addr = '0; dst_addr = '0; length = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b exp 0", done); end
      checks++; if (bus.M_req !== 1'b0)  begin errors++; $display("FAIL rst_req: got %b exp 0", bus.M_req); end
      checks++; if (bus.M_wr !== 1'b0)   begin errors++; $display("FAIL rst_wr: got %b exp 0", bus.M_wr); end
      checks++; if (bus.M_addr !== '0)   begin errors++; $display("FAIL rst_addr: got %h exp 0", bus.M_addr); end
      checks++; if (bus.M_dout !== '0)   begin errors++; $display("FAIL rst_dout: got %h exp 0", bus.M_dout); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_copy;
      int w0 = nwrites;
      push_copy(8'h00, 8'h20, 4);
      start_copy(8'h00, 8'h20, 8'd4);
      watch(20, 0, 0, 0);
      checks++; if (first_done != 15) begin errors++; $display("FAIL copy_done_time: got %0d exp 15", first_done); end
      checks++; if (done_cnt != 1)    begin errors++; $display("FAIL copy_done_cnt: got %0d exp 1", done_cnt); end
      checks++; if (busy_h[1] !== 1'b1)  begin errors++; $display("FAIL copy_busy_t1: got %b exp 1", busy_h[1]); end
      checks++; if (busy_h[15] !== 1'b1) begin errors++; $display("FAIL copy_busy_t15: got %b exp 1", busy_h[15]); end
      checks++; if (busy_h[16] !== 1'b0) begin errors++; $display("FAIL copy_busy_t16: got %b exp 0", busy_h[16]); end
      checks++; if (nwrites - w0 != 4)   begin errors++; $display("FAIL copy_nwr: got %0d exp 4", nwrites - w0); end
      checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL copy_pending: got %0d exp 0", exp_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (s1[i] !== 32'hA0 + 32'(i)) begin
            errors++; $display("FAIL copy_mem[%0d]: got %h exp %h", i, s1[i], 32'hA0 + 32'(i));
         end
      end
   endtask

   task automatic test_zero_len;
      int w0 = nwrites;
      start_copy(8'h00, 8'h20, 8'd0);
      watch(6, 0, 0, 0);
      checks++; if (first_done != 1) begin errors++; $display("FAIL zl_done_time: got %0d exp 1", first_done); end
      checks++; if (done_cnt != 1)   begin errors++; $display("FAIL zl_done_cnt: got %0d exp 1", done_cnt); end
      checks++; if (req_cnt != 0)    begin errors++; $display("FAIL zl_req: got %0d exp 0", req_cnt); end
      checks++; if (busy_h[2] !== 1'b0) begin errors++; $display("FAIL zl_busy_t2: got %b exp 0", busy_h[2]); end
      checks++; if (nwrites != w0)   begin errors++; $display("FAIL zl_nwr: got %0d exp 0", nwrites - w0); end
   endtask

   task automatic test_wrap;
      int w0 = nwrites;
      push_copy(8'hFE, 8'h20, 3);
      start_copy(8'hFE, 8'h20, 8'd3);
      watch(16, 0, 0, 0);
      checks++; if (first_done != 12) begin errors++; $display("FAIL wrap_done_time: got %0d exp 12", first_done); end
      checks++; if (nwrites - w0 != 3) begin errors++; $display("FAIL wrap_nwr: got %0d exp 3", nwrites - w0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d exp 0", exp_q.size()); end
   endtask

   task automatic test_restart_ignored;
      int w0 = nwrites;
      push_copy(8'h00, 8'h24, 4);
      start_copy(8'h00, 8'h24, 8'd4);
      watch(24, 0, 0, 5);
      checks++; if (first_done != 15) begin errors++; $display("FAIL rs_done_time: got %0d exp 15", first_done); end
      checks++; if (done_cnt != 1)    begin errors++; $display("FAIL rs_done_cnt: got %0d exp 1", done_cnt); end
      checks++; if (nwrites - w0 != 4) begin errors++; $display("FAIL rs_nwr: got %0d exp 4", nwrites - w0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rs_pending: got %0d exp 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid;
      int w0 = nwrites;
      push_copy(8'h00, 8'h28, 2);
      start_copy(8'h00, 8'h28, 8'd4);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.M_wr !== 1'b1) begin errors++; $display("FAIL rm_in_wr: got %b exp 1", bus.M_wr); end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.M_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b exp 0", bus.M_req); end
      checks++; if (bus.M_wr !== 1'b0)  begin errors++; $display("FAIL rm_wr: got %b exp 0", bus.M_wr); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rm_busy: got %b exp 0", busy); end
      @(posedge clk); #1;
      watch(10, 0, 0, 0);
      checks++; if (done_cnt != 0)      begin errors++; $display("FAIL rm_done: got %0d exp 0", done_cnt); end
      checks++; if (nwrites - w0 != 2)  begin errors++; $display("FAIL rm_nwr: got %0d exp 2", nwrites - w0); end
      checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL rm_pending: got %0d exp 0", exp_q.size()); end
   endtask

   task automatic test_grant_loss;
      int w0 = nwrites;
      push_copy(8'h00, 8'h2C, 4);
      start_copy(8'h00, 8'h2C, 8'd4);
      watch(24, 6, 8, 0);
      checks++; if (first_done != 19) begin errors++; $display("FAIL gl_done_time: got %0d exp 19", first_done); end
      checks++; if (nwrites - w0 != 4) begin errors++; $display("FAIL gl_nwr: got %0d exp 4", nwrites - w0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gl_pending: got %0d exp 0", exp_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (s1[12+i] !== 32'hA0 + 32'(i)) begin
            errors++; $display("FAIL gl_mem[%0d]: got %h exp %h", i, s1[12+i], 32'hA0 + 32'(i));
         end
      end
   endtask

   initial begin
      test_reset;
      test_copy;
      test_zero_len;
      test_wrap;
      test_restart_ignored;
      test_reset_mid;
      test_grant_loss;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
